fir_window_loader: RTL

Upstream feeder for the 10-tap dot-product stage. Accepts a serial 4-bit sample stream over a valid/ready handshake and holds a 10-sample sliding window. Holds a 10-entry coefficient bank written by address. Presents the window and coefficients as flat buses that map directly onto the dot-product x0..x9 / h0..h9 inputs, plus a one-cycle strobe each time a complete new window is ready.

---
 rtl/fir_window_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/fir_window_loader.sv
// Serial sample loader for the 10-tap dot-product: keeps a sliding window and a coefficient bank.
// Window/coefficients update one cycle after the accepting edge; s_ready drops while coef_we or flush is asserted.
module fir_window_loader #(
    parameter int TAPS = 10,
    parameter int DW   = 4,
    parameter int AW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [DW-1:0]        s_data,
    output logic                 s_ready,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic [DW-1:0]        coef_data,
    input  logic                 flush,
    output logic [TAPS*DW-1:0]   x_bus,
    output logic [TAPS*DW-1:0]   h_bus,
    output logic                 win_valid,
    output logic [AW-1:0]        fill_cnt,
    output logic [15:0]          win_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TAPS*DW-1:0]  x_q, x_d;
    logic [TAPS*DW-1:0]  h_q, h_d;
    logic                win_valid_q, win_valid_d;
    logic [AW-1:0]       fill_cnt_q, fill_cnt_d;
    logic [15:0]         win_cnt_q, win_cnt_d;
    logic                accept;

    // Stalling on coef_we keeps coefficient updates and window shifts in separate cycles.
    assign s_ready = reset & ~coef_we & ~flush;
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        h_d         = h_q;
        win_valid_d = 1'b0;
        fill_cnt_d  = fill_cnt_q;
        win_cnt_d   = win_cnt_q;

        if (flush) begin
            x_d        = '0;
            fill_cnt_d = '0;
            state_d    = EMPTY;
        end else if (accept) begin
            x_d = {x_q[(TAPS-1)*DW-1:0], s_data};
            if (fill_cnt_q < AW'(TAPS)) begin
                fill_cnt_d = fill_cnt_q + AW'(1);
            end
            if (fill_cnt_d == AW'(TAPS)) begin
                win_valid_d = 1'b1;
                win_cnt_d   = win_cnt_q + 16'd1;
            end
            case (state_q)
                EMPTY:   state_d = (fill_cnt_d == AW'(TAPS)) ? FULL : FILL;
                FILL:    state_d = (fill_cnt_d == AW'(TAPS)) ? FULL : FILL;
                FULL:    state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end

        // Out-of-range addresses match no entry and are dropped.
        if (coef_we) begin
            for (int i = 0; i < TAPS; i++) begin
                if (coef_addr == AW'(i)) begin
                    h_d[i*DW +: DW] = coef_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            x_q         <= '0;
            h_q         <= '0;
            win_valid_q <= 1'b0;
            fill_cnt_q  <= '0;
            win_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            h_q         <= h_d;
            win_valid_q <= win_valid_d;
            fill_cnt_q  <= fill_cnt_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    assign x_bus     = x_q;
    assign h_bus     = h_q;
    assign win_valid = win_valid_q;
    assign fill_cnt  = fill_cnt_q;
    assign win_cnt   = win_cnt_q;

endmodule
